cpu_fetch_pq: RTL and testbench
===============================

Name: cpu_fetch_pq

Overview:
- Parametrised successor fetch unit for the moxie core.
- Prefetches 32-bit words from instruction memory into a halfword-granular prefetch queue.
- Presents the head opcode, plus the following 32-bit operand, to decode.
- Adds over the previous fetch unit: req/ack memory handshake, configurable queue depth, halfword-aligned branch targets, variable-length (2- or 6-byte) instruction pops, and discarding of in-flight fetches on a branch.

Parameters:
- BOOT_ADDRESS, 32'h00001000: reset fetch and PC address (word aligned).
- DEPTH_HW, 8: queue depth in 16-bit halfwords. Power of 2, at least 4.
- PTR_W, 3: pointer width; equals log2(DEPTH_HW).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- imem_address_o, out, 32: word-aligned fetch address.
- imem_req_o, out, 1: fetch request.
- imem_ack_i, in, 1: memory ack; imem_data_i is valid in this cycle.
- imem_data_i, in, 32: fetched word, big-endian. Bits [31:16] are the lower-addressed halfword.
- branch_flag_i, in, 1: redirect request.
- branch_target_i, in, 32: redirect target; bit 0 ignored.
- stall_i, in, 1: pipeline interlock.
- read_en_i, in, 1: decode consumes the head instruction.
- long_i, in, 1: head instruction is 6 bytes (pop 3 halfwords), else 2 bytes (pop 1).
- opcode_o, out, 16: head halfword.
- operand_o, out, 32: halfwords head+1 and head+2, concatenated.
- valid_o, out, 1: queue holds at least 1 halfword.
- long_valid_o, out, 1: queue holds at least 3 halfwords.
- PC_o, out, 32: byte address of the head halfword.

Behaviour:
- Reset (rst_i high at a clock edge, overriding everything):
  - Queue empty; valid_o = long_valid_o = 0.
  - PC_o = BOOT_ADDRESS; imem_address_o = BOOT_ADDRESS; imem_req_o = 0.
  - Drop flag and skip flag cleared.
  - Reset mid-transaction: req drops the next cycle. The memory treats a req deassertion as an abort, and an ack without req is ignored.
- Queue:
  - Circular buffer of DEPTH_HW halfwords with wrapping read/write pointers and a count register (width PTR_W+1).
  - opcode_o and operand_o are read combinationally from the head slots (with wrap). Contents beyond count are don't-care.
- Request FSM, states IDLE and WAIT:
  - IDLE to WAIT when count + 2 <= DEPTH_HW, with no branch and no reset. imem_req_o = 1.
  - In WAIT, imem_req_o and imem_address_o are held stable until imem_ack_i.
  - On ack: return to IDLE, address += 4. If space allows, re-request in the same cycle; zero bubble on back-to-back fetch.
  - At most one request outstanding.
- Push on ack, unless drop is set:
  - Write both halfwords, count += 2.
  - If skip is set, write only [15:0], count += 1, then clear skip.
- Pop, when read_en_i && !stall_i && !branch:
  - long_i = 0 and valid_o = 1: pop 1, PC_o += 2.
  - long_i = 1 and long_valid_o = 1: pop 3, PC_o += 6.
  - Otherwise no pop and no error.
  - Push and pop in the same cycle both take effect; count updates by the net amount.
- Branch accepted when branch_flag_i && !stall_i:
  - Flush the queue (count = 0, pointers reset) and ignore read_en_i.
  - PC_o = {target[31:1], 1'b0}; next fetch address = {target[31:2], 2'b00}; skip = target[1].
  - If in WAIT and no ack this cycle: set drop. The next ack is discarded, then a new request is issued to the new address.
  - If ack arrives in the branch cycle: its data is discarded.
  - A later branch while drop is set re-targets the address; drop stays set.
- branch_flag_i with stall_i high: ignored, no state change.
- Latency:
  - Ack in cycle N gives valid_o in cycle N+1.
  - Zero-wait memory (ack in the same cycle as req): first valid_o 2 cycles after reset release or after an accepted branch.

Optional Feature:
- Macro: CPU_FETCH_PQ_STATS_EN.
- Defined: adds outputs stat_fetch_o[31:0] and stat_flush_o[31:0].
  - stat_fetch_o counts accepted non-dropped acks.
  - stat_flush_o counts accepted branches that discarded at least one valid halfword or an in-flight request.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory returning 32'h2E012E02 at 0x1000:
  - First req address = 0x1000.
  - valid_o = 1 with opcode_o = 16'h2E01 and PC_o = 0x1000.
  - After a short pop: opcode_o = 16'h2E02, PC_o = 0x1002.
- Long instruction split across words (0x01A0_1234 then 0x5678_xxxx):
  - long_valid_o = 1, operand_o = 32'h12345678.
  - Pop with long_i = 1 gives PC_o = 0x1006.
- Branch to 0x2002:
  - Fetch at 0x2000; only the low halfword is enqueued.
  - PC_o = 0x2002; opcode_o = data[15:0].
- Branch while a request to 0x1008 waits 3 cycles for ack:
  - That ack's data is never enqueued.
  - Next req address = branch target word.
  - stat_flush_o increments by 1 (with the macro defined).
- DEPTH_HW = 8, no reads:
  - Count saturates at 8; no req is issued while count > 6.
  - One short pop does not re-trigger req (7 + 2 > 8); after a second pop, req re-asserts.
- stall_i high with read_en_i and branch_flag_i high: PC_o, queue contents and count unchanged.

Source files
------------

// File: rtl/cpu_fetch_pq.sv
// rtl/cpu_fetch_pq.sv - halfword prefetch-queue fetch unit; CPU_FETCH_PQ_STATS_EN adds fetch/flush counters
module cpu_fetch_pq #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000,
  parameter int          DEPTH_HW     = 8,
  parameter int          PTR_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_address_o,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  input  logic        read_en_i,
  input  logic        long_i,
  output logic [15:0] opcode_o,
  output logic [31:0] operand_o,
  output logic        valid_o,
  output logic        long_valid_o,
  output logic [31:0] PC_o
`ifdef CPU_FETCH_PQ_STATS_EN
  ,
  output logic [31:0] stat_fetch_o,
  output logic [31:0] stat_flush_o
`endif
);

  localparam int CW = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [15:0]      mem_q [DEPTH_HW];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [31:0]      pc_q;
  logic             drop_q, drop_d;
  logic             skip_q;

  logic             branch_acc;
  logic             ack_acc;
  logic             push_en;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic             room_q, room_d;
  logic [31:0]      tgt_word;

  assign branch_acc = branch_flag_i && !stall_i;
  assign ack_acc    = (state_q == ST_WAIT) && imem_ack_i;
  assign push_en    = ack_acc && !drop_q && !branch_acc;
  assign push_n     = push_en ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign tgt_word   = branch_target_i & ~32'd3;

  assign valid_o      = (count_q != '0);
  assign long_valid_o = (int'(count_q) >= 3);
  assign opcode_o     = mem_q[rd_ptr_q];
  assign operand_o    = {mem_q[rd_ptr_q + PTR_W'(1)], mem_q[rd_ptr_q + PTR_W'(2)]};
  assign PC_o           = pc_q;
  assign imem_address_o = addr_q;
  assign imem_req_o     = (state_q == ST_WAIT);

  // pop amount: short pops need one halfword, long pops need three; otherwise hold
  always_comb begin
    pop_n = 2'd0;
    if (read_en_i && !stall_i && !branch_acc) begin
      if (long_i) begin
        if (long_valid_o) pop_n = 2'd3;
      end else if (valid_o) begin
        pop_n = 2'd1;
      end
    end
  end

  assign count_d = count_q + CW'(push_n) - CW'(pop_n);
  assign room_q  = (int'(count_q) + 2) <= DEPTH_HW;
  assign room_d  = (int'(count_d) + 2) <= DEPTH_HW;

  // request FSM: one outstanding fetch, address held until ack, redirect deferred while in flight
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    drop_d  = drop_q;
    if (state_q == ST_IDLE) begin
      if (branch_acc) addr_d = tgt_word;
      else if (room_q) state_d = ST_WAIT;
    end else if (imem_ack_i) begin
      drop_d = 1'b0;
      if (branch_acc) begin
        addr_d  = tgt_word;
        state_d = ST_IDLE;
      end else if (drop_q) begin
        // queue was flushed and nothing pushed since, so there is room to refetch now
        addr_d  = tgt_q;
        state_d = ST_WAIT;
      end else begin
        addr_d  = addr_q + 32'd4;
        state_d = room_d ? ST_WAIT : ST_IDLE;
      end
    end else if (branch_acc) begin
      drop_d = 1'b1;
      tgt_d  = tgt_word;
    end
  end

  // control state, pointers, count and PC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= BOOT_ADDRESS;
      tgt_q    <= BOOT_ADDRESS;
      pc_q     <= BOOT_ADDRESS;
      drop_q   <= 1'b0;
      skip_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      if (branch_acc) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        pc_q     <= branch_target_i & ~32'd1;
        skip_q   <= branch_target_i[1];
      end else begin
        count_q  <= count_d;
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
        pc_q     <= pc_q + {29'd0, pop_n, 1'b0};
        if (push_en) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
          skip_q   <= 1'b0;
        end
      end
    end
  end

  // queue storage: big-endian word split into two halfwords, or low half only after an odd target
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_en) begin
      if (skip_q) begin
        mem_q[wr_ptr_q] <= imem_data_i[15:0];
      end else begin
        mem_q[wr_ptr_q]               <= imem_data_i[31:16];
        mem_q[wr_ptr_q + PTR_W'(1)]   <= imem_data_i[15:0];
      end
    end
  end

`ifdef CPU_FETCH_PQ_STATS_EN
  // fetch and flush event counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_fetch_o <= '0;
      stat_flush_o <= '0;
    end else begin
      if (push_en) stat_fetch_o <= stat_fetch_o + 32'd1;
      if (branch_acc && (count_q != '0 || state_q == ST_WAIT))
        stat_flush_o <= stat_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_fetch_pq.sv
// tb/tb_cpu_fetch_pq.sv - directed scoreboard bench for cpu_fetch_pq
module tb_cpu_fetch_pq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_address_o;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic        read_en_i;
  logic        long_i;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic        valid_o;
  logic        long_valid_o;
  logic [31:0] PC_o;
`ifdef CPU_FETCH_PQ_STATS_EN
  logic [31:0] stat_fetch_o;
  logic [31:0] stat_flush_o;
`endif

  cpu_fetch_pq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_address_o(imem_address_o), .imem_req_o(imem_req_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_i(stall_i), .read_en_i(read_en_i), .long_i(long_i),
    .opcode_o(opcode_o), .operand_o(operand_o), .valid_o(valid_o),
    .long_valid_o(long_valid_o), .PC_o(PC_o)
`ifdef CPU_FETCH_PQ_STATS_EN
    , .stat_fetch_o(stat_fetch_o), .stat_flush_o(stat_flush_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  logic [31:0] mem_lo [4];
  logic [31:0] ack_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] cur_pc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return mem_lo[a[3:2]];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    if (i < ack_q.size()) return ack_q[i];
    return 'x;
  endfunction

  // memory model: ack after lat waiting cycles, zero-wait when lat is 0
  assign imem_ack_i  = imem_req_o && (wcnt >= lat);
  assign imem_data_i = imem_ack_i ? word_at(imem_address_o) : 32'hDEADBEEF;

  always @(posedge clk_i) begin
    if (!imem_req_o || imem_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (imem_req_o) req_cycles <= req_cycles + 1;
    if (imem_ack_i) ack_q.push_back(imem_address_o);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; branch_flag_i = 1'b0; read_en_i = 1'b0; long_i = 1'b0; stall_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    cur_pc = 32'h1000;
  endtask

  task automatic wait_valid(input string tag, input int maxc, output int n);
    n = 0;
    while (!valid_o && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(valid_o), 32'd1);
  endtask

  task automatic pop(input logic lg);
    logic [31:0] e;
    read_en_i = 1'b1;
    long_i = lg;
    exp_q.push_back(cur_pc + (lg ? 32'd6 : 32'd2));
    step();
    read_en_i = 1'b0;
    long_i = 1'b0;
    e = exp_q.pop_front();
    cur_pc = e;
    chk("pop_pc", PC_o, e);
    chk("pop_opcode", 32'(opcode_o), 32'(hw_at(e)));
  endtask

  task automatic branch_to(input logic [31:0] t);
    branch_flag_i = 1'b1;
    branch_target_i = t;
    ack_q.delete();
    step();
    branch_flag_i = 1'b0;
    cur_pc = t & ~32'd1;
  endtask

  initial begin
    int n, n2, rc;
    logic [31:0] sv_pc, sv_opd;
    logic [15:0] sv_op;
`ifdef CPU_FETCH_PQ_STATS_EN
    logic [31:0] sv_flush;
`endif
    rst_i = 1'b1; branch_flag_i = 1'b0; branch_target_i = '0;
    stall_i = 1'b0; read_en_i = 1'b0; long_i = 1'b0;
    mem_lo = '{32'h2E012E02, 32'h11112222, 32'h33334444, 32'h55556666};
    lat = 0;

    // reset state
    repeat (3) step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_long_valid", 32'(long_valid_o), 32'd0);
    chk("rst_pc", PC_o, 32'h1000);
    chk("rst_addr", imem_address_o, 32'h1000);
    chk("rst_req", 32'(imem_req_o), 32'd0);

    // boot fetch, zero-wait memory
    rst_i = 1'b0;
    cur_pc = 32'h1000;
    n = 0;
    while (!imem_req_o && n < 10) begin step(); n++; end
    chk("first_req_addr", imem_address_o, 32'h1000);
    wait_valid("boot_valid", 10, n2);
    chk("boot_latency", 32'(n + n2), 32'd2);
    chk("boot_long_valid", 32'(long_valid_o), 32'd0);
    chk("boot_opcode", 32'(opcode_o), 32'h2E01);
    chk("boot_pc", PC_o, 32'h1000);
    pop(1'b0);

    // long instruction spanning two words
    mem_lo = '{32'h01A01234, 32'h56789ABC, 32'h33334444, 32'h55556666};
    do_reset();
    n = 0;
    while (!long_valid_o && n < 10) begin step(); n++; end
    chk("long_valid", 32'(long_valid_o), 32'd1);
    chk("long_opcode", 32'(opcode_o), 32'h01A0);
    chk("long_operand", operand_o, 32'h12345678);
    pop(1'b1);
    chk("long_pc", PC_o, 32'h1006);

    // queue depth limit with no reads
    do_reset();
    repeat (12) step();
    chk("full_req_low", 32'(imem_req_o), 32'd0);
    rc = req_cycles;
    repeat (4) step();
    chk("full_no_req", 32'(req_cycles), 32'(rc));
    pop(1'b0);
    repeat (4) step();
    chk("seven_no_req", 32'(req_cycles), 32'(rc));
    pop(1'b0);
    repeat (4) step();
    chk("six_req", 32'(req_cycles), 32'(rc + 1));
    repeat (5) pop(1'b0);

    // branch to an odd halfword
    branch_to(32'h00002002);
    wait_valid("br_valid", 10, n);
    chk("br_latency", 32'(n), 32'd2);
    chk("br_fetch_addr", ack_at(0), 32'h2000);
    chk("br_pc", PC_o, 32'h2002);
    chk("br_opcode", 32'(opcode_o), 32'(hw_at(32'h2002)));
    pop(1'b0);

    // branch while a slow fetch is in flight
    lat = 3;
    do_reset();
    n = 0;
    while (!(imem_req_o && imem_address_o == 32'h1008) && n < 40) begin step(); n++; end
    chk("slow_req_1008", imem_address_o, 32'h1008);
`ifdef CPU_FETCH_PQ_STATS_EN
    sv_flush = stat_flush_o;
`endif
    branch_to(32'h00003000);
    wait_valid("drop_valid", 30, n);
    chk("drop_pc", PC_o, 32'h3000);
    chk("drop_opcode", 32'(opcode_o), 32'h3000);
    chk("drop_ack0", ack_at(0), 32'h1008);
    chk("drop_ack1", ack_at(1), 32'h3000);
`ifdef CPU_FETCH_PQ_STATS_EN
    chk("stat_flush", stat_flush_o, sv_flush + 32'd1);
`endif

    // stall blocks both pop and branch
    lat = 0;
    repeat (12) step();
    sv_pc = PC_o; sv_op = opcode_o; sv_opd = operand_o;
    stall_i = 1'b1; read_en_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h4000;
    repeat (3) step();
    chk("stall_pc", PC_o, sv_pc);
    chk("stall_opcode", 32'(opcode_o), 32'(sv_op));
    chk("stall_operand", operand_o, sv_opd);
    chk("stall_valid", 32'(long_valid_o), 32'd1);
    stall_i = 1'b0; read_en_i = 1'b0; branch_flag_i = 1'b0;
    pop(1'b0);
    pop(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
